key_debounce_multi: RTL and testbench

//  Parametrised N-channel push-button conditioner; successor to the fixed two-key debouncer.
//  Per channel: 2-FF synchroniser, independent debounce counter, debounced level,

---
 rtl/key_debounce_multi_pkg.sv | 25 ++
 rtl/key_debounce_ch.sv | 131 +++++++++++++
 rtl/key_debounce_multi.sv | 39 +++
 tb/tb_key_debounce_multi.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_multi_pkg.sv
// Shared types, timing defaults and sizing helpers for the multi-key debouncer.
package key_debounce_multi_pkg;

  typedef enum logic [1:0] {
    HOLD_IDLE   = 2'd0,
    HOLD_HOLD   = 2'd1,
    HOLD_REPEAT = 2'd2,
    HOLD_DONE   = 2'd3
  } hold_state_e;

  localparam int DEF_N_KEYS          = 4;
  localparam int DEF_ACTIVE_LOW      = 1;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_LONG_CYCLES     = 50_000_000;
  localparam int DEF_REPEAT_CYCLES   = 10_000_000;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce counter, debounced level and hold FSM.
//   state       | meaning
//   HOLD_IDLE   | key released, no hold timing
//   HOLD_HOLD   | pressed, counting towards the long-press point
//   HOLD_REPEAT | long press fired, emitting periodic repeat pulses
//   HOLD_DONE   | long press fired, repeat disabled, waiting for release
module key_debounce_ch
  import key_debounce_multi_pkg::*;
#(
  parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(max2(LONG_CYCLES, REPEAT_CYCLES));
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0] D_TC = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] L_TC = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] R_TC = (REPEAT_CYCLES == 0) ? '0 : HW'(REPEAT_CYCLES - 1);

  logic          s0_q, s0_d, s1_q, s1_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d, release_q, release_d;
  logic          long_q, long_d, repeat_q, repeat_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  hold_state_e   state_q, state_d;
  logic          rise, fall;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      hcnt_q    <= '0;
      state_q   <= HOLD_IDLE;
    end else begin
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      hcnt_q    <= hcnt_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    // Synchroniser stores the normalised level: 1 = pressed, reset = released.
    s0_d    = key_raw_i ^ POL;
    s1_d    = s0_q;
    level_d = level_q;
    dcnt_d  = '0;
    rise    = 1'b0;
    fall    = 1'b0;
    if (s1_q != level_q) begin
      if (dcnt_q == D_TC) begin
        level_d = s1_q;
        rise    = s1_q;
        fall    = ~s1_q;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
    press_d   = rise;
    release_d = fall;

    state_d  = state_q;
    hcnt_d   = hcnt_q;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    if (fall) begin
      state_d = HOLD_IDLE;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        HOLD_IDLE: begin
          if (rise) begin
            state_d = HOLD_HOLD;
            hcnt_d  = '0;
          end
        end
        HOLD_HOLD: begin
          if (hcnt_q == L_TC) begin
            long_d  = 1'b1;
            hcnt_d  = '0;
            state_d = (REPEAT_CYCLES == 0) ? HOLD_DONE : HOLD_REPEAT;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        HOLD_REPEAT: begin
          if (hcnt_q == R_TC) begin
            repeat_d = 1'b1;
            hcnt_d   = '0;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        HOLD_DONE: ;
        default: state_d = HOLD_IDLE;
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner; each key gets a fully independent channel.
module key_debounce_multi
  import key_debounce_multi_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk_50m  (clk_50m),
      .rst_n    (rst_n),
      .key_raw_i(key_in[g]),
      .level_o  (key_level[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .long_o   (key_long[g]),
      .repeat_o (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: active-low build with repeat, active-high build without repeat.
module tb_key_debounce_multi;

  localparam int NK  = 4;
  localparam int D   = 8;
  localparam int L   = 32;
  localparam int R_A = 8;

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  logic [NK-1:0] press_a = '0;
  logic [NK-1:0] press_b = '0;
  logic [NK-1:0] key_a, key_b;
  logic [NK-1:0] a_lvl, a_prs, a_rel, a_lng, a_rpt;
  logic [NK-1:0] b_lvl, b_prs, b_rel, b_lng, b_rpt;

  assign key_a = ~press_a;
  assign key_b = press_b;

  always #5 clk_50m = ~clk_50m;

  key_debounce_multi #(.N_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
                       .LONG_CYCLES(L), .REPEAT_CYCLES(R_A)) dut_a (
    .clk_50m(clk_50m), .rst_n(rst_n), .key_in(key_a), .key_level(a_lvl),
    .key_press(a_prs), .key_release(a_rel), .key_long(a_lng), .key_repeat(a_rpt));

  key_debounce_multi #(.N_KEYS(NK), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(D),
                       .LONG_CYCLES(L), .REPEAT_CYCLES(0)) dut_b (
    .clk_50m(clk_50m), .rst_n(rst_n), .key_in(key_b), .key_level(b_lvl),
    .key_press(b_prs), .key_release(b_rel), .key_long(b_lng), .key_repeat(b_rpt));

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: level flips once the last D synchronised samples all disagree with it;
  // long/repeat follow from the hold age measured from the accepted press.
  bit          hist [2][NK][D+2];
  bit          lvl  [2][NK];
  int          age  [2][NK];
  logic [NK-1:0] e_lvl [2], e_prs [2], e_rel [2], e_lng [2], e_rpt [2];
  bit smp, all_flip;
  int rep_p;

  always @(posedge clk_50m) begin
    for (int i = 0; i < 2; i++) begin
      rep_p = (i == 0) ? R_A : 0;
      for (int c = 0; c < NK; c++) begin
        e_prs[i][c] = 1'b0; e_rel[i][c] = 1'b0; e_lng[i][c] = 1'b0; e_rpt[i][c] = 1'b0;
        if (!rst_n) begin
          for (int j = 0; j < D + 2; j++) hist[i][c][j] = 1'b0;
          lvl[i][c] = 1'b0;
          age[i][c] = 0;
        end else begin
          smp = (i == 0) ? !key_a[c] : key_b[c];
          for (int j = D + 1; j > 0; j--) hist[i][c][j] = hist[i][c][j-1];
          hist[i][c][0] = smp;
          all_flip = 1'b1;
          for (int j = 2; j < D + 2; j++) if (hist[i][c][j] == lvl[i][c]) all_flip = 1'b0;
          if (all_flip) begin
            lvl[i][c] = !lvl[i][c];
            if (lvl[i][c]) begin
              e_prs[i][c] = 1'b1;
              age[i][c] = 0;
            end else begin
              e_rel[i][c] = 1'b1;
            end
          end else if (lvl[i][c]) begin
            age[i][c]++;
            e_lng[i][c] = (age[i][c] == L);
            e_rpt[i][c] = (rep_p > 0) && (age[i][c] > L) && (((age[i][c] - L) % rep_p) == 0);
          end
        end
        e_lvl[i][c] = lvl[i][c];
      end
    end
  end

  int cnt_prs [2][NK], cnt_rel [2][NK], cnt_lng [2][NK], cnt_rpt [2][NK];
  int s_prs [2][NK], s_rel [2][NK], s_lng [2][NK], s_rpt [2][NK];

  initial begin
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < NK; c++) begin
        cnt_prs[i][c] = 0; cnt_rel[i][c] = 0; cnt_lng[i][c] = 0; cnt_rpt[i][c] = 0;
      end
  end

  always @(negedge clk_50m) begin
    if (!rst_n) begin
      check_eq("rst_a", {a_lvl, a_prs, a_rel, a_lng, a_rpt}, 32'd0);
      check_eq("rst_b", {b_lvl, b_prs, b_rel, b_lng, b_rpt}, 32'd0);
    end else begin
      check_eq("a_level",   a_lvl, e_lvl[0]);
      check_eq("a_press",   a_prs, e_prs[0]);
      check_eq("a_release", a_rel, e_rel[0]);
      check_eq("a_long",    a_lng, e_lng[0]);
      check_eq("a_repeat",  a_rpt, e_rpt[0]);
      check_eq("b_level",   b_lvl, e_lvl[1]);
      check_eq("b_press",   b_prs, e_prs[1]);
      check_eq("b_release", b_rel, e_rel[1]);
      check_eq("b_long",    b_lng, e_lng[1]);
      check_eq("b_repeat",  b_rpt, e_rpt[1]);
      for (int c = 0; c < NK; c++) begin
        cnt_prs[0][c] += int'(a_prs[c]); cnt_rel[0][c] += int'(a_rel[c]);
        cnt_lng[0][c] += int'(a_lng[c]); cnt_rpt[0][c] += int'(a_rpt[c]);
        cnt_prs[1][c] += int'(b_prs[c]); cnt_rel[1][c] += int'(b_rel[c]);
        cnt_lng[1][c] += int'(b_lng[c]); cnt_rpt[1][c] += int'(b_rpt[c]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic snap();
    s_prs = cnt_prs; s_rel = cnt_rel; s_lng = cnt_lng; s_rpt = cnt_rpt;
  endtask

  int remain [NK];

  initial begin
    tick(5);
    rst_n = 1'b1;
    tick(5);

    // Clean press on both builds, held 100 cycles.
    snap();
    press_a[0] = 1'b1;
    press_b[0] = 1'b1;
    tick(100);
    press_a[0] = 1'b0;
    press_b[0] = 1'b0;
    tick(20);
    check_eq("t1_press",   32'(cnt_prs[0][0] - s_prs[0][0]), 32'd1);
    check_eq("t1_release", 32'(cnt_rel[0][0] - s_rel[0][0]), 32'd1);
    check_eq("t1_long",    32'(cnt_lng[0][0] - s_lng[0][0]), 32'd1);
    check_eq("t1_repeat",  32'(cnt_rpt[0][0] - s_rpt[0][0]), 32'd8);
    check_eq("t6_press",   32'(cnt_prs[1][0] - s_prs[1][0]), 32'd1);
    check_eq("t6_long",    32'(cnt_lng[1][0] - s_lng[1][0]), 32'd1);
    check_eq("t6_repeat",  32'(cnt_rpt[1][0] - s_rpt[1][0]), 32'd0);

    // Bounce on key 1 with random sub-debounce intervals, then a steady press.
    snap();
    for (int k = 0; k < 10; k++) begin
      press_a[1] = ~press_a[1];
      tick($urandom_range(1, 3));
    end
    press_a[1] = 1'b1;
    tick(60);
    press_a[1] = 1'b0;
    tick(20);
    check_eq("t2_press",   32'(cnt_prs[0][1] - s_prs[0][1]), 32'd1);
    check_eq("t2_release", 32'(cnt_rel[0][1] - s_rel[0][1]), 32'd1);

    // Short press on key 2.
    snap();
    press_a[2] = 1'b1;
    tick(20);
    press_a[2] = 1'b0;
    tick(20);
    check_eq("t3_press",   32'(cnt_prs[0][2] - s_prs[0][2]), 32'd1);
    check_eq("t3_release", 32'(cnt_rel[0][2] - s_rel[0][2]), 32'd1);
    check_eq("t3_long",    32'(cnt_lng[0][2] - s_lng[0][2]), 32'd0);
    check_eq("t3_repeat",  32'(cnt_rpt[0][2] - s_rpt[0][2]), 32'd0);

    // Keys 0 and 3 together; release 3 only.
    snap();
    press_a[0] = 1'b1;
    press_a[3] = 1'b1;
    tick(15);
    press_a[3] = 1'b0;
    tick(30);
    check_eq("t4_press0",  32'(cnt_prs[0][0] - s_prs[0][0]), 32'd1);
    check_eq("t4_press3",  32'(cnt_prs[0][3] - s_prs[0][3]), 32'd1);
    check_eq("t4_rel3",    32'(cnt_rel[0][3] - s_rel[0][3]), 32'd1);
    check_eq("t4_rel0",    32'(cnt_rel[0][0] - s_rel[0][0]), 32'd0);
    check_eq("t4_long0",   32'(cnt_lng[0][0] - s_lng[0][0]), 32'd1);
    check_eq("t4_long3",   32'(cnt_lng[0][3] - s_lng[0][3]), 32'd0);
    tick(20);

    // Reset pulse while key 0 is in auto-repeat.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    snap();
    tick(30);
    check_eq("t5_press0", 32'(cnt_prs[0][0] - s_prs[0][0]), 32'd1);
    check_eq("t5_level0", 32'(a_lvl[0]), 32'd1);
    press_a = '0;
    tick(20);

    // Random activity on all channels of both builds.
    for (int c = 0; c < NK; c++) remain[c] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < NK; c++) begin
        if (remain[c] == 0) begin
          press_a[c] = ~press_a[c];
          remain[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 80))
                                                  : int'($urandom_range(1, 12));
        end else begin
          remain[c]--;
        end
      end
      press_b = press_a;
      tick(1);
    end
    press_a = '0;
    press_b = '0;
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
